// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx
// ---------------------------------------------------------------------------
// Receives PS/2 keyboard frames (start, 8 data bits LSB first, odd parity,
// stop), decodes the F0 (break) and E0 (extended) prefixes and presents
// set-2 scan codes to the downstream controller / LCD keycode input.
//
// Ports:
//   clk          in   system clock, all logic on posedge
//   rst          in   synchronous active-high reset
//   ps2_clk      in   raw PS/2 clock (asynchronous)
//   ps2_data     in   raw PS/2 data (asynchronous)
//   keycode      out  last non-prefix scan code, held until the next one
//   key_extended out  code was preceded by E0; updates with keycode
//   key_valid    out  one-cycle strobe, make code delivered
//   key_release  out  one-cycle strobe, break code (F0 xx) delivered
//   frame_err    out  one-cycle strobe, parity / stop / timeout error
// ---------------------------------------------------------------------------
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_extended,
    output logic       key_valid,
    output logic       key_release,
    output logic       frame_err
);

    localparam int              TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]      FILT_LAST = 8'(FILTER_LEN - 1);
    localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // Stage p0/p1: two-flop synchronizers, idle level is 1
    logic clk_sync_p0, clk_sync_p1;
    logic data_sync_p0, data_sync_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_p0  <= 1'b1;
            clk_sync_p1  <= 1'b1;
            data_sync_p0 <= 1'b1;
            data_sync_p1 <= 1'b1;
        end else begin
            clk_sync_p0  <= ps2_clk;
            clk_sync_p1  <= clk_sync_p0;
            data_sync_p0 <= ps2_data;
            data_sync_p1 <= data_sync_p0;
        end
    end

    // Stage p2: glitch filter on the synchronized clock
    logic       clk_filt_p2;
    logic       clk_filt_d;
    logic [7:0] filt_cnt;
    logic       fall;

    // filt_cnt counts consecutive samples that disagree with the filtered
    // level; the FILTER_LEN-th disagreeing sample flips the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_filt_p2 <= 1'b1;
            clk_filt_d  <= 1'b1;
            filt_cnt    <= 8'd0;
        end else begin
            clk_filt_d <= clk_filt_p2;
            if (clk_sync_p1 == clk_filt_p2) begin
                filt_cnt <= 8'd0;
            end else if (filt_cnt == FILT_LAST) begin
                clk_filt_p2 <= clk_sync_p1;
                filt_cnt    <= 8'd0;
            end else begin
                filt_cnt <= filt_cnt + 8'd1;
            end
        end
    end

    assign fall = clk_filt_d & ~clk_filt_p2;

    // Frame FSM and timeout
    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [TW-1:0] to_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic          stop_edge;
    logic          frame_ok;
    logic          byte_good;
    logic          byte_bad;
    logic          timeout;

    assign stop_edge = fall && (state == ST_STOP);
    // Odd parity: XOR over data and parity bits must be 1; stop must be 1.
    assign frame_ok  = data_sync_p1 && (^{shreg, par_bit});
    assign byte_good = stop_edge && frame_ok;
    assign byte_bad  = stop_edge && !frame_ok;
    assign timeout   = (state != ST_IDLE) && !fall && (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= 3'd0;
            to_cnt  <= '0;
        end else begin
            if (state == ST_IDLE || fall) begin
                to_cnt <= '0;
            end else if (!timeout) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (timeout) begin
                state   <= ST_IDLE;
                bit_cnt <= 3'd0;
            end else if (fall) begin
                case (state)
                    ST_IDLE: begin
                        // A falling edge with data high is not a start bit.
                        if (!data_sync_p1) begin
                            state   <= ST_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: state <= ST_STOP;
                    default:   state <= ST_IDLE;
                endcase
            end
        end
    end

    // Data-path capture; contents are qualified by the FSM so need no reset
    always_ff @(posedge clk) begin
        if (fall && state == ST_DATA) begin
            shreg <= {data_sync_p1, shreg[7:1]};
        end
        if (fall && state == ST_PARITY) begin
            par_bit <= data_sync_p1;
        end
    end

    // Stage p3: byte decode and registered outputs
    logic brk_flag;
    logic ext_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            keycode      <= 8'd0;
            key_extended <= 1'b0;
            key_valid    <= 1'b0;
            key_release  <= 1'b0;
            frame_err    <= 1'b0;
            brk_flag     <= 1'b0;
            ext_flag     <= 1'b0;
        end else begin
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            frame_err   <= 1'b0;
            if (byte_bad || timeout) begin
                frame_err <= 1'b1;
                brk_flag  <= 1'b0;
                ext_flag  <= 1'b0;
            end else if (byte_good) begin
                case (shreg)
                    8'hF0: brk_flag <= 1'b1;
                    8'hE0: ext_flag <= 1'b1;
                    default: begin
                        keycode      <= shreg;
                        key_extended <= ext_flag;
                        if (brk_flag) begin
                            key_release <= 1'b1;
                        end else begin
                            key_valid <= 1'b1;
                        end
                        brk_flag <= 1'b0;
                        ext_flag <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx
// ---------------------------------------------------------------------------
// Scoreboard bench for ps2_keyboard_rx. Stimulus tasks bit-bang PS/2 frames
// and push the expected decoded event into a queue; a monitor pops and
// compares whenever the DUT raises a strobe.
// ---------------------------------------------------------------------------
module tb_ps2_keyboard_rx;

    localparam int FL   = 8;
    localparam int TO   = 1200;
    localparam int HALF = 20;

    localparam int EV_VALID   = 0;
    localparam int EV_RELEASE = 1;
    localparam int EV_ERR     = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keycode;
    logic       key_extended;
    logic       key_valid;
    logic       key_release;
    logic       frame_err;

    ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .keycode      (keycode),
        .key_extended (key_extended),
        .key_valid    (key_valid),
        .key_release  (key_release),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        logic [7:0] code;
        logic       ext;
    } ev_t;

    ev_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model state: what the keyboard protocol says the outputs are
    logic       m_brk  = 1'b0;
    logic       m_ext  = 1'b0;
    logic [7:0] m_code = 8'd0;
    logic       m_kext = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int kind);
        ev_t e;
        e.kind = kind;
        e.code = m_code;
        e.ext  = m_kext;
        exp_q.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            push_ev(EV_ERR);
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else begin
            m_code = b;
            m_kext = m_ext;
            push_ev(m_brk ? EV_RELEASE : EV_VALID);
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    // One PS/2 bit: data set while clock is high, then a full low phase.
    // A glitch is a FILTER_LEN-1 cycle low pulse inside the high phase.
    task automatic send_bit(input logic v, input bit glitch);
        ps2_data = v;
        if (glitch) begin
            tick(5);
            ps2_clk = 1'b0;
            tick(FL - 1);
            ps2_clk = 1'b1;
            tick(HALF - 5 - (FL - 1));
        end else begin
            tick(HALF);
        end
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input bit bad_stop, input int glitch_idx);
        logic [10:0] bits;
        bits[0]   = 1'b0;
        bits[8:1] = b;
        bits[9]   = ~(^b) ^ bad_par;
        bits[10]  = ~bad_stop;
        model_byte(b, !bad_par && !bad_stop);
        for (int i = 0; i < 11; i++) begin
            send_bit(bits[i], i == glitch_idx);
        end
        ps2_data = 1'b1;
        tick(3 * HALF);
    endtask

    task automatic good_frame(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, -1);
    endtask

    // Start bit plus n data bits, line then left idle-high
    task automatic partial_frame(input int n);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            send_bit(1'($urandom_range(0, 1)), 1'b0);
        end
        ps2_data = 1'b1;
    endtask

    // Monitor: every strobe cycle consumes one expected event
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && (key_valid || key_release || frame_err)) begin
                int nstr;
                int kind;
                ev_t e;
                nstr = int'(key_valid) + int'(key_release) + int'(frame_err);
                chk("one_strobe", nstr, 1);
                kind = frame_err ? EV_ERR : (key_release ? EV_RELEASE : EV_VALID);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe kind=%0d keycode=%0h required=none", kind, keycode);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_kind", kind, e.kind);
                    chk("keycode", keycode, e.code);
                    chk("key_extended", key_extended, e.ext);
                end
            end
        end
    end

    initial begin
        tick(4);
        chk("rst_keycode", keycode, 0);
        chk("rst_ext", key_extended, 0);
        chk("rst_strobes", {key_valid, key_release, frame_err}, 0);
        rst = 1'b0;
        tick(20);
        chk("idle_strobes", {key_valid, key_release, frame_err}, 0);

        // Basic make, break, extended
        good_frame(8'h45);
        good_frame(8'hF0);
        good_frame(8'h5A);
        good_frame(8'hE0);
        good_frame(8'h6B);
        good_frame(8'h16);

        // Parity and stop errors, then recovery
        send_frame(8'h1C, 1'b1, 1'b0, -1);
        good_frame(8'h1C);
        good_frame(8'hF0);
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        good_frame(8'h1C);

        // Both prefix orders give an extended release
        good_frame(8'hE0);
        good_frame(8'hF0);
        good_frame(8'h70);
        good_frame(8'hF0);
        good_frame(8'hE0);
        good_frame(8'h71);

        // Timeout aborts a partial frame and clears the pending E0
        good_frame(8'hE0);
        partial_frame(5);
        push_ev(EV_ERR);
        m_brk = 1'b0;
        m_ext = 1'b0;
        tick(TO + 50);
        good_frame(8'h29);

        // Glitches shorter than the filter, idle and mid-frame
        ps2_clk = 1'b0;
        tick(FL - 1);
        ps2_clk = 1'b1;
        tick(HALF);
        send_frame(8'h66, 1'b0, 1'b0, 4);

        // Spurious falling edge in idle with data high
        send_bit(1'b1, 1'b0);
        tick(HALF);
        good_frame(8'h45);
        good_frame(8'h45);
        good_frame(8'h45);

        // Reset mid-frame discards a pending F0 and the partial byte
        good_frame(8'hF0);
        partial_frame(3);
        tick(HALF);
        rst = 1'b1;
        tick(3);
        chk("midrst_keycode", keycode, 0);
        chk("midrst_ext", key_extended, 0);
        chk("midrst_strobes", {key_valid, key_release, frame_err}, 0);
        m_brk  = 1'b0;
        m_ext  = 1'b0;
        m_code = 8'd0;
        m_kext = 1'b0;
        rst = 1'b0;
        tick(20);
        good_frame(8'h5A);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            int         r;
            logic [7:0] b;
            bit         bp;
            bit         bs;
            int         g;
            r  = int'($urandom_range(0, 99));
            if (r < 20)      b = 8'hF0;
            else if (r < 35) b = 8'hE0;
            else             b = 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 9) == 0);
            bs = ($urandom_range(0, 14) == 0);
            g  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1;
            send_frame(b, bp, bs, g);
        end

        // Drain: every expected event must have been seen
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) begin
            tick(1);
        end
        chk("queue_drained", exp_q.size(), 0);
        tick(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
